// File: rtl/add_shifted_a_inverse_dsp19x2.sv
// Recovers the two 10-bit A lanes from packed DSP19x2 "add shifted A" results and flags inconsistent encodings.
// Optional statistics counters are built only when DSP19X2_INV_STATS_EN is defined.
module add_shifted_a_inverse_dsp19x2 #(
   parameter int LANE_W = 19,
   parameter int A_W    = 10,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2*LANE_W-1:0] z_in,
   input  logic [17:0]         b_in,
   input  logic [4:0]          acc_fir,
   input  logic [9:0]          coeff0,
   input  logic [9:0]          coeff1,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*A_W-1:0]    a_out,
   output logic [1:0]          err,
   output logic [CNT_W-1:0]    err_count,
   output logic [CNT_W-1:0]    xfer_count
);

   localparam int D_W = LANE_W + 1;
   localparam logic [D_W-1:0] A_MAX = D_W'((1 << A_W) - 1);

   // Returns {err, a} for one lane.
   function automatic logic [A_W:0] recover_lane(input logic [LANE_W-1:0] lane,
                                                 input logic [LANE_W-1:0] p,
                                                 input logic [4:0]        sh);
      logic [D_W-1:0] d;
      logic [D_W-1:0] q;
      logic           e;
      logic [A_W-1:0] a;
      d = {1'b0, lane} - {1'b0, p};
      q = '0;
      e = 1'b0;
      a = '0;
      if (d[D_W-1]) begin
         e = 1'b1;
      end else begin
         q = d >> sh;
         e = ((q << sh) != d);
         if (q > A_MAX) begin
            a = '1;
            e = 1'b1;
         end else begin
            a = q[A_W-1:0];
         end
      end
      return {e, a};
   endfunction

   logic                s1_valid_q, s1_valid_d;
   logic [LANE_W-1:0]   p0_q, p0_d, p1_q, p1_d;
   logic [LANE_W-1:0]   z0_q, z0_d, z1_q, z1_d;
   logic [4:0]          sh_q, sh_d;
   logic                s2_valid_q, s2_valid_d;
   logic [2*A_W-1:0]    a_q, a_d;
   logic [1:0]          err_q, err_d;
   logic                s2_load;
   logic                out_xfer;
   logic [A_W:0]        r0, r1;

   assign s2_load   = !s2_valid_q || out_ready;
   // NOTE: in_ready depends combinationally on out_ready so a full pipe can still accept while draining.
   assign in_ready  = !s1_valid_q || s2_load;
   assign out_xfer  = s2_valid_q && out_ready;
   assign out_valid = s2_valid_q;
   assign a_out     = a_q;
   assign err       = err_q;

   assign r0 = recover_lane(z0_q, p0_q, sh_q);
   assign r1 = recover_lane(z1_q, p1_q, sh_q);

   // NOTE: every always_comb output gets a hold default first so no latch is inferred.
   always_comb begin
      s1_valid_d = s1_valid_q;
      p0_d       = p0_q;
      p1_d       = p1_q;
      z0_d       = z0_q;
      z1_d       = z1_q;
      sh_d       = sh_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            p0_d = LANE_W'(coeff0) * LANE_W'(b_in[8:0]);
            p1_d = LANE_W'(coeff1) * LANE_W'(b_in[17:9]);
            z0_d = z_in[LANE_W-1:0];
            z1_d = z_in[2*LANE_W-1:LANE_W];
            sh_d = acc_fir;
         end
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      a_d        = a_q;
      err_d      = err_q;
      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            a_d   = {r1[A_W-1:0], r0[A_W-1:0]};
            err_d = {r1[A_W], r0[A_W]};
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments; data registers are reset too since a_out/err must read 0 after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         p0_q       <= '0;
         p1_q       <= '0;
         z0_q       <= '0;
         z1_q       <= '0;
         sh_q       <= '0;
         s2_valid_q <= 1'b0;
         a_q        <= '0;
         err_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         p0_q       <= p0_d;
         p1_q       <= p1_d;
         z0_q       <= z0_d;
         z1_q       <= z1_d;
         sh_q       <= sh_d;
         s2_valid_q <= s2_valid_d;
         a_q        <= a_d;
         err_q      <= err_d;
      end
   end

`ifdef DSP19X2_INV_STATS_EN
   logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Both counters saturate at all-ones instead of wrapping.
   always_comb begin
      xfer_cnt_d = xfer_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (out_xfer) begin
         if (xfer_cnt_q != '1) xfer_cnt_d = xfer_cnt_q + 1'b1;
         if ((err_q != 2'b00) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         xfer_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         xfer_cnt_q <= xfer_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign xfer_count = xfer_cnt_q;
   assign err_count  = err_cnt_q;
`else
   assign xfer_count = '0;
   assign err_count  = '0;
`endif

endmodule
